// File: rtl/butterfly_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_pipe
//
// Radix-2 complex butterfly with a 3-stage pipeline:
//   X = A + W*B,  Y = A - W*B
// Optional conjugate twiddle (inverse transform) and an optional halving of
// both results (block-floating-point stage). The results saturate to DATA_W
// bits, and a sticky flag records any clamp.
//
// Stage plan
//   S1 : register A, the scale bit and the four partial products of B*W
//        (W imaginary part already conjugated when i_inverse = 1)
//   S2 : combine the partial products into the complex product, round
//        half-up back to data scale (DATA_W+2 bits)
//   S3 : add/subtract, optional halving, saturation, output registers
//
// Handshake (one rule for the whole block)
//   An input beat is taken on a rising edge where i_valid && o_ready. An
//   output beat is consumed on a rising edge where o_valid && i_ready. The
//   whole pipeline advances on en = !o_valid || i_ready and o_ready = en, so
//   when the output is stalled every stage (data, valid and mode bits)
//   holds and o_data_* stays stable.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_data_ra/ca, i_data_rb/cb    operand A (re, im), operand B (re, im)
//   i_twiddle_r/c                 twiddle W (re, im), Q1.FRAC_W
//   i_valid / o_ready             input beat handshake
//   i_inverse                     1 = use conj(W) for this beat
//   i_scale                       1 = halve X and Y for this beat
//   o_data_ra/ca, o_data_rb/cb    X (re, im), Y (re, im)
//   o_valid / i_ready             output beat handshake
//   o_ovf / i_clr_ovf             sticky saturation flag and its clear
// ---------------------------------------------------------------------------
module butterfly_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int FRAC_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] i_data_ra,
  input  logic signed [DATA_W-1:0] i_data_ca,
  input  logic signed [DATA_W-1:0] i_data_rb,
  input  logic signed [DATA_W-1:0] i_data_cb,
  input  logic signed [TW_W-1:0]   i_twiddle_r,
  input  logic signed [TW_W-1:0]   i_twiddle_c,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_inverse,
  input  logic                     i_scale,
  output logic signed [DATA_W-1:0] o_data_ra,
  output logic signed [DATA_W-1:0] o_data_ca,
  output logic signed [DATA_W-1:0] o_data_rb,
  output logic signed [DATA_W-1:0] o_data_cb,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_ovf,
  input  logic                     i_clr_ovf
);

  // Full-precision product width, rounded product width, sum width.
  localparam int PW = DATA_W + TW_W + 2;
  localparam int RW = DATA_W + 2;
  localparam int SW = DATA_W + 3;

  // Half an LSB of the rounded product, for round-half-up.
  localparam logic signed [PW-1:0] RND = PW'(1) << (FRAC_W - 1);

  // Output clamp limits, expressed at sum width.
  localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(64'sd1 <<< (DATA_W - 1)));

  // -------------------------------------------------------------------------
  // Global pipeline enable
  // -------------------------------------------------------------------------
  logic en;
  assign en      = !o_valid || i_ready;
  assign o_ready = en;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Optional halving with rounding: (v + 1) >>> 1.
  function automatic logic signed [SW-1:0] half_opt(input logic signed [SW-1:0] v,
                                                    input logic               s);
    logic signed [SW-1:0] t;
    t = v + SW'(1);
    return s ? (t >>> 1) : v;
  endfunction

  function automatic logic clamps(input logic signed [SW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [DATA_W-1:0] r;
    if (v > SAT_MAX)      r = DATA_W'(SAT_MAX);
    else if (v < SAT_MIN) r = DATA_W'(SAT_MIN);
    else                  r = DATA_W'(v);
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Stage 1: operands and partial products
  // -------------------------------------------------------------------------
  logic                     v1_q, v1_d;
  logic                     scl1_q, scl1_d;
  logic signed [DATA_W-1:0] ar1_q, ar1_d, ai1_q, ai1_d;
  logic signed [PW-1:0]     pp_rr_q, pp_rr_d;   // br * wr
  logic signed [PW-1:0]     pp_ii_q, pp_ii_d;   // bi * wi_eff
  logic signed [PW-1:0]     pp_ri_q, pp_ri_d;   // br * wi_eff
  logic signed [PW-1:0]     pp_ir_q, pp_ir_d;   // bi * wr

  // One extra bit so that negating the most negative twiddle is exact.
  logic signed [TW_W:0]   wc_ext, wi_eff;
  logic signed [PW-1:0]   br_x, bi_x, wr_x, wi_x;

  always_comb begin
    wc_ext  = {i_twiddle_c[TW_W-1], i_twiddle_c};
    wi_eff  = i_inverse ? -wc_ext : wc_ext;

    br_x    = {{(PW-DATA_W){i_data_rb[DATA_W-1]}}, i_data_rb};
    bi_x    = {{(PW-DATA_W){i_data_cb[DATA_W-1]}}, i_data_cb};
    wr_x    = {{(PW-TW_W){i_twiddle_r[TW_W-1]}}, i_twiddle_r};
    wi_x    = {{(PW-TW_W-1){wi_eff[TW_W]}}, wi_eff};

    // Operands are pre-extended to PW, and every true product needs fewer
    // than PW bits, so keeping the low PW bits of the product is exact.
    pp_rr_d = br_x * wr_x;
    pp_ii_d = bi_x * wi_x;
    pp_ri_d = br_x * wi_x;
    pp_ir_d = bi_x * wr_x;

    v1_d    = i_valid;
    scl1_d  = i_scale;
    ar1_d   = i_data_ra;
    ai1_d   = i_data_ca;
  end

  // -------------------------------------------------------------------------
  // Stage 2: complex product, rounded half-up to data scale
  // -------------------------------------------------------------------------
  logic                     v2_q, v2_d;
  logic                     scl2_q, scl2_d;
  logic signed [DATA_W-1:0] ar2_q, ar2_d, ai2_q, ai2_d;
  logic signed [RW-1:0]     pr2_q, pr2_d, pi2_q, pi2_d;

  logic signed [PW-1:0]     pr_full, pi_full;

  always_comb begin
    pr_full = pp_rr_q - pp_ii_q;
    pi_full = pp_ri_q + pp_ir_q;
    pr2_d   = RW'((pr_full + RND) >>> FRAC_W);
    pi2_d   = RW'((pi_full + RND) >>> FRAC_W);
    v2_d    = v1_q;
    scl2_d  = scl1_q;
    ar2_d   = ar1_q;
    ai2_d   = ai1_q;
  end

  // -------------------------------------------------------------------------
  // Stage 3: sum / difference, optional halving, saturation
  // -------------------------------------------------------------------------
  logic                     v3_q, v3_d;
  logic signed [DATA_W-1:0] xr_q, xr_d, xi_q, xi_d, yr_q, yr_d, yi_q, yi_d;
  logic                     ovf_q, ovf_d;

  logic signed [SW-1:0]     a_r, a_i, p_r, p_i;
  logic signed [SW-1:0]     xs_r, xs_i, ys_r, ys_i;
  logic                     any_clamp;

  always_comb begin
    a_r  = SW'(ar2_q);
    a_i  = SW'(ai2_q);
    p_r  = SW'(pr2_q);
    p_i  = SW'(pi2_q);

    xs_r = half_opt(a_r + p_r, scl2_q);
    xs_i = half_opt(a_i + p_i, scl2_q);
    ys_r = half_opt(a_r - p_r, scl2_q);
    ys_i = half_opt(a_i - p_i, scl2_q);

    xr_d = sat(xs_r);
    xi_d = sat(xs_i);
    yr_d = sat(ys_r);
    yi_d = sat(ys_i);
    v3_d = v2_q;

    any_clamp = clamps(xs_r) || clamps(xs_i) || clamps(ys_r) || clamps(ys_i);

    // Clear first, so a clamp landing in the same cycle wins. Only a valid
    // beat actually moving into S3 may set the flag; bubbles never do.
    ovf_d = ovf_q;
    if (i_clr_ovf) ovf_d = 1'b0;
    if (en && v2_q && any_clamp) ovf_d = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      scl1_q  <= 1'b0;
      ar1_q   <= '0;
      ai1_q   <= '0;
      pp_rr_q <= '0;
      pp_ii_q <= '0;
      pp_ri_q <= '0;
      pp_ir_q <= '0;
      v2_q    <= 1'b0;
      scl2_q  <= 1'b0;
      ar2_q   <= '0;
      ai2_q   <= '0;
      pr2_q   <= '0;
      pi2_q   <= '0;
      v3_q    <= 1'b0;
      xr_q    <= '0;
      xi_q    <= '0;
      yr_q    <= '0;
      yi_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        v1_q    <= v1_d;
        scl1_q  <= scl1_d;
        ar1_q   <= ar1_d;
        ai1_q   <= ai1_d;
        pp_rr_q <= pp_rr_d;
        pp_ii_q <= pp_ii_d;
        pp_ri_q <= pp_ri_d;
        pp_ir_q <= pp_ir_d;
        v2_q    <= v2_d;
        scl2_q  <= scl2_d;
        ar2_q   <= ar2_d;
        ai2_q   <= ai2_d;
        pr2_q   <= pr2_d;
        pi2_q   <= pi2_d;
        v3_q    <= v3_d;
        xr_q    <= xr_d;
        xi_q    <= xi_d;
        yr_q    <= yr_d;
        yi_q    <= yi_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_valid   = v3_q;
  assign o_data_ra = xr_q;
  assign o_data_ca = xi_q;
  assign o_data_rb = yr_q;
  assign o_data_cb = yi_q;
  assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_butterfly_pipe
//
// Bench for butterfly_pipe. Inputs are driven on the falling edge; DUT
// outputs are observed on the falling edge before new inputs are applied.
// Every accepted beat pushes its expected result (computed with plain
// integer arithmetic from X = A + W*B, Y = A - W*B) onto exp_q; every
// consumed output pops it. The sticky flag is tracked alongside.
// ---------------------------------------------------------------------------
module tb_butterfly_pipe;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam int FW = 15;
  localparam int EW = 4 * DW + 1;   // {clamp, xr, xi, yr, yi}

  typedef struct {
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [TW-1:0] wr, wi;
    logic                 inv, scl;
  } beat_t;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic signed [DW-1:0] i_data_ra = '0, i_data_ca = '0, i_data_rb = '0, i_data_cb = '0;
  logic signed [TW-1:0] i_twiddle_r = '0, i_twiddle_c = '0;
  logic i_valid = 1'b0, i_inverse = 1'b0, i_scale = 1'b0, i_ready = 1'b1, i_clr_ovf = 1'b0;
  logic signed [DW-1:0] o_data_ra, o_data_ca, o_data_rb, o_data_cb;
  logic o_ready, o_valid, o_ovf;

  butterfly_pipe #(.DATA_W(DW), .TW_W(TW), .FRAC_W(FW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_data_ra   (i_data_ra),
    .i_data_ca   (i_data_ca),
    .i_data_rb   (i_data_rb),
    .i_data_cb   (i_data_cb),
    .i_twiddle_r (i_twiddle_r),
    .i_twiddle_c (i_twiddle_c),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_inverse   (i_inverse),
    .i_scale     (i_scale),
    .o_data_ra   (o_data_ra),
    .o_data_ca   (o_data_ca),
    .o_data_rb   (o_data_rb),
    .o_data_cb   (o_data_cb),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_ovf       (o_ovf),
    .i_clr_ovf   (i_clr_ovf)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_out    = 0;
  logic          exp_ovf  = 1'b0;
  logic          prev_rst = 1'b1;
  logic          prev_clr = 1'b0;
  logic          prev_ov  = 1'b0;
  logic          prev_cons = 1'b0;
  beat_t         idle_b;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, floor shifts on signed longint.
  function automatic logic [EW-1:0] model(input beat_t b);
    longint wi, pr, pi, p_r, p_i;
    longint v[4];
    longint mx, mn;
    logic [DW-1:0] o[4];
    logic clamp;
    mx = (longint'(1) <<< (DW - 1)) - 1;
    mn = -(longint'(1) <<< (DW - 1));
    wi = b.inv ? -longint'(b.wi) : longint'(b.wi);
    pr = longint'(b.br) * longint'(b.wr) - longint'(b.bi) * wi;
    pi = longint'(b.br) * wi + longint'(b.bi) * longint'(b.wr);
    p_r = (pr + (longint'(1) <<< (FW - 1))) >>> FW;
    p_i = (pi + (longint'(1) <<< (FW - 1))) >>> FW;
    v[0] = longint'(b.ar) + p_r;
    v[1] = longint'(b.ai) + p_i;
    v[2] = longint'(b.ar) - p_r;
    v[3] = longint'(b.ai) - p_i;
    clamp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (b.scl) v[k] = (v[k] + 1) >>> 1;
      if (v[k] > mx) begin v[k] = mx; clamp = 1'b1; end
      if (v[k] < mn) begin v[k] = mn; clamp = 1'b1; end
      o[k] = DW'(v[k]);
    end
    return {clamp, o[0], o[1], o[2], o[3]};
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.ar  = DW'($urandom);
    b.ai  = DW'($urandom);
    b.br  = DW'($urandom);
    b.bi  = DW'($urandom);
    b.wr  = TW'($urandom);
    b.wi  = TW'($urandom);
    b.inv = 1'($urandom_range(0, 1));
    b.scl = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic beat_t mk(input int ar, ai, br, bi, wr, wi, input logic inv, scl);
    beat_t b;
    b.ar = DW'(ar); b.ai = DW'(ai); b.br = DW'(br); b.bi = DW'(bi);
    b.wr = TW'(wr); b.wi = TW'(wi); b.inv = inv; b.scl = scl;
    return b;
  endfunction

  // ---------------------------------------------------------------- driver
  // One clock cycle: check what the DUT shows now, then apply new inputs and
  // update the scoreboard for the edge about to come.
  task automatic cycle(input beat_t b, input logic vld, input logic rdy,
                       input logic clr, input logic r, output logic acc);
    logic [EW-1:0] e;
    logic en_m, cons;
    @(negedge clk);
    if (prev_rst) exp_ovf = 1'b0;
    else begin
      if (prev_clr) exp_ovf = 1'b0;
      if (o_valid && (!prev_ov || prev_cons) && exp_q.size() != 0 && exp_q[0][EW-1])
        exp_ovf = 1'b1;
    end
    check_val("ovf", o_ovf, exp_ovf);
    if (exp_q.size() == 0) check_val("valid_idle", o_valid, 0);
    else if (o_valid) begin
      e = exp_q[0];
      check_val("x_re", o_data_ra, $signed(e[4*DW-1:3*DW]));
      check_val("x_im", o_data_ca, $signed(e[3*DW-1:2*DW]));
      check_val("y_re", o_data_rb, $signed(e[2*DW-1:DW]));
      check_val("y_im", o_data_cb, $signed(e[DW-1:0]));
    end
    prev_ov = o_valid;

    i_data_ra = b.ar; i_data_ca = b.ai; i_data_rb = b.br; i_data_cb = b.bi;
    i_twiddle_r = b.wr; i_twiddle_c = b.wi; i_inverse = b.inv; i_scale = b.scl;
    i_valid = vld; i_ready = rdy; i_clr_ovf = clr; rst = r;
    #1;
    en_m = !o_valid || rdy;
    check_val("o_ready", o_ready, en_m);
    acc  = vld && en_m && !r;
    cons = o_valid && rdy;
    if (r) exp_q.delete();
    else begin
      if (cons) begin void'(exp_q.pop_front()); n_out++; end
      if (acc) exp_q.push_back(model(b));
    end
    prev_cons = cons && !r;
    prev_clr  = clr;
    prev_rst  = r;
  endtask

  task automatic tick(input logic rdy);
    logic acc;
    cycle(idle_b, 1'b0, rdy, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) tick(1'b1);
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_valid"}, o_valid, 0);
    check_val({tag, "_ready"}, o_ready, 1);
    check_val({tag, "_ovf"}, o_ovf, 0);
    check_val({tag, "_xr"}, o_data_ra, 0);
    check_val({tag, "_xi"}, o_data_ca, 0);
    check_val({tag, "_yr"}, o_data_rb, 0);
    check_val({tag, "_yi"}, o_data_cb, 0);
  endtask

  // Single beat into an empty pipe; result must appear exactly 3 cycles later.
  task automatic directed(input string tag, input beat_t b, input longint xr, xi, yr, yi,
                          input logic ovf);
    logic acc;
    cycle(b, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    check_val({tag, "_acc"}, o_ready, 1);
    tick(1'b1);
    tick(1'b1);
    check_val({tag, "_lat2"}, o_valid, 0);
    tick(1'b1);
    check_val({tag, "_lat3"}, o_valid, 1);
    check_val({tag, "_xr"}, o_data_ra, xr);
    check_val({tag, "_xi"}, o_data_ca, xi);
    check_val({tag, "_yr"}, o_data_rb, yr);
    check_val({tag, "_yi"}, o_data_cb, yi);
    check_val({tag, "_ovf"}, o_ovf, ovf);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic acc;
    int   accepted, cyc, out0;
    idle_b = mk(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    // Reset
    for (int i = 0; i < 3; i++) cycle(idle_b, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    check_reset_state("reset");

    // Identity twiddle, first beat right after reset release
    directed("ident", mk(1000, 0, 500, 0, 32767, 0, 1'b0, 1'b0), 1500, 0, 500, 0, 1'b0);
    directed("ident_scl", mk(1000, 0, 500, 0, 32767, 0, 1'b0, 1'b1), 750, 0, 250, 0, 1'b0);

    // -j twiddle, forward and inverse
    directed("negj", mk(0, 0, 0, 100, 0, -32768, 1'b0, 1'b0), 100, 0, -100, 0, 1'b0);
    directed("negj_inv", mk(0, 0, 0, 100, 0, -32768, 1'b1, 1'b0), -100, 0, 100, 0, 1'b0);

    // Saturation, sticky flag, clear
    directed("sat", mk(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0), 32767, 0, 1, 0, 1'b1);
    tick(1'b1);
    tick(1'b1);
    check_val("ovf_hold", o_ovf, 1);
    cycle(idle_b, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    tick(1'b1);
    check_val("ovf_clr", o_ovf, 0);
    drain();

    // Backpressure: 6 beats, i_ready low on cycles 4..8
    accepted = 0;
    out0 = n_out;
    for (cyc = 0; cyc < 40 && accepted < 6; cyc++) begin
      cycle(rand_beat(), 1'b1, !(cyc >= 4 && cyc <= 8), 1'b0, 1'b0, acc);
      if (acc) accepted++;
      if (cyc >= 4 && cyc <= 8) check_val("bp_ready_low", o_ready, 0);
    end
    drain();
    check_val("bp_count", n_out - out0, 6);

    // Reset with beats in flight
    for (int i = 0; i < 3; i++) cycle(rand_beat(), 1'b1, 1'b1, 1'b0, 1'b0, acc);
    cycle(idle_b, 1'b0, 1'b1, 1'b0, 1'b1, acc);
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    directed("post_rst", mk(1000, 0, 500, 0, 32767, 0, 1'b0, 1'b0), 1500, 0, 500, 0, 1'b0);
    drain();

    // Randomized traffic
    accepted = 0;
    for (int i = 0; i < 60000 && accepted < 10000; i++) begin
      cycle(rand_beat(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 63) == 0, 1'b0, acc);
      if (acc) accepted++;
    end
    check_val("rand_accepted", accepted, 10000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
